// File: rtl/xsleena_pkg.sv
// Shared types and constants for the background-layer ROM fetch path.
// Latency and backpressure are defined by the modules that import this package.
package xsleena_pkg;
  localparam int ROM_AW = 17;
  localparam int ROM_DW = 16;
  localparam int SD_AW_DEF = 22;
  localparam logic [SD_AW_DEF-1:0] B1_BASE_DEF = 22'h000000;
  localparam logic [SD_AW_DEF-1:0] B2_BASE_DEF = 22'h020000;

  typedef enum logic [1:0] {IDLE, READ, DONE} fetch_state_t;
  typedef enum logic {CH_B1 = 1'b0, CH_B2 = 1'b1} chan_t;
endpackage

// File: rtl/xsleena_rom_req_chan.sv
// One layer's request capture, pending slot, last-fetch tag filter and data/valid register.
// Tag hit: valid 1 clk after req. Miss: waits for grant/fill; a newer req overwrites the pending one.
module xsleena_rom_req_chan
  import xsleena_pkg::*;
(
  input  logic              clk,
  input  logic              RESETn,
  input  logic              req,
  input  logic [ROM_AW-1:0] addr,
  input  logic              grant,
  input  logic              fill,
  input  logic [ROM_AW-1:0] fill_tag,
  input  logic [ROM_DW-1:0] fill_dat,
  output logic              pend,
  output logic [ROM_AW-1:0] pend_addr,
  output logic [ROM_DW-1:0] data,
  output logic              valid
);
  logic [ROM_AW-1:0] tag;
  logic              tag_valid;
  logic              hit;

  // Only the committed tag is consulted, so a repeat of an in-flight address still misses.
  assign hit = tag_valid && (addr == tag);

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
      data      <= 16'hFFFF;
      valid     <= 1'b0;
    end else begin
      valid <= fill || (req && hit);
      if (req && !hit) begin
        pend      <= 1'b1;
        pend_addr <= addr;
      end else if (grant) begin
        pend <= 1'b0;
      end
      if (fill) begin
        data      <= fill_dat;
        tag       <= fill_tag;
        tag_valid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/xsleena_bg_rom_fetch.sv
// Arbitrates BACK1/BACK2 tile ROM fetches onto one SDRAM read port, round-robin, BACK2 first after reset.
// Miss: sd_rd 1 clk after capture, data/valid 1 clk after sd_ack; sd_rd held until sd_ack, then low >=1 clk.
module xsleena_bg_rom_fetch
  import xsleena_pkg::*;
#(
  parameter int                B_SD_AW_UNUSED = 0,
  parameter int                SD_AW   = SD_AW_DEF,
  parameter logic [SD_AW-1:0]  B1_BASE = B1_BASE_DEF,
  parameter logic [SD_AW-1:0]  B2_BASE = B2_BASE_DEF
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic              b1_req,
  input  logic [ROM_AW-1:0] b1_addr,
  output logic [ROM_DW-1:0] b1_data,
  output logic              b1_valid,
  input  logic              b2_req,
  input  logic [ROM_AW-1:0] b2_addr,
  output logic [ROM_DW-1:0] b2_data,
  output logic              b2_valid,
  output logic [SD_AW-1:0]  sd_addr,
  output logic              sd_rd,
  input  logic              sd_ack,
  input  logic [ROM_DW-1:0] sd_dout
);
  fetch_state_t      state_q, state_d;
  chan_t             sel_q, sel_d, last_q, last_d, pick;
  logic [SD_AW-1:0]  sd_addr_q, sd_addr_d;
  logic              sd_rd_q, sd_rd_d;
  logic [ROM_AW-1:0] cur_addr_q, cur_addr_d;
  logic              pend1, pend2, grant1, grant2, fill1, fill2;
  logic [ROM_AW-1:0] pend_addr1, pend_addr2;

  xsleena_rom_req_chan u_b1 (
    .clk(clk), .RESETn(RESETn), .req(b1_req), .addr(b1_addr),
    .grant(grant1), .fill(fill1), .fill_tag(cur_addr_q), .fill_dat(sd_dout),
    .pend(pend1), .pend_addr(pend_addr1), .data(b1_data), .valid(b1_valid)
  );

  xsleena_rom_req_chan u_b2 (
    .clk(clk), .RESETn(RESETn), .req(b2_req), .addr(b2_addr),
    .grant(grant2), .fill(fill2), .fill_tag(cur_addr_q), .fill_dat(sd_dout),
    .pend(pend2), .pend_addr(pend_addr2), .data(b2_data), .valid(b2_valid)
  );

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state_q    <= IDLE;
      sel_q      <= CH_B2;
      last_q     <= CH_B1;
      sd_addr_q  <= '0;
      sd_rd_q    <= 1'b0;
      cur_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      sd_addr_q  <= sd_addr_d;
      sd_rd_q    <= sd_rd_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    sd_addr_d  = sd_addr_q;
    sd_rd_d    = sd_rd_q;
    cur_addr_d = cur_addr_q;
    pick       = CH_B2;
    grant1     = 1'b0;
    grant2     = 1'b0;
    fill1      = 1'b0;
    fill2      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend1 || pend2) begin
          if (pend1 && pend2) pick = (last_q == CH_B1) ? CH_B2 : CH_B1;
          else                pick = pend2 ? CH_B2 : CH_B1;
          sel_d   = pick;
          last_d  = pick;
          sd_rd_d = 1'b1;
          state_d = READ;
          if (pick == CH_B2) begin
            cur_addr_d = pend_addr2;
            sd_addr_d  = B2_BASE + {{(SD_AW-ROM_AW){1'b0}}, pend_addr2};
            grant2     = 1'b1;
          end else begin
            cur_addr_d = pend_addr1;
            sd_addr_d  = B1_BASE + {{(SD_AW-ROM_AW){1'b0}}, pend_addr1};
            grant1     = 1'b1;
          end
        end
      end
      READ: begin
        if (sd_ack) begin
          fill1   = (sel_q == CH_B1);
          fill2   = (sel_q == CH_B2);
          sd_rd_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sd_addr = sd_addr_q;
  assign sd_rd   = sd_rd_q;
endmodule
